// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the MIPS controllers: opcodes, functs, ALU codes,
// datapath mux encodings and the multi-cycle sequencer state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BGTZ  = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] F_SLL     = 6'd0;
    localparam logic [5:0] F_SRL     = 6'd2;
    localparam logic [5:0] F_SRA     = 6'd3;
    localparam logic [5:0] F_SLLV    = 6'd4;
    localparam logic [5:0] F_JR      = 6'd8;
    localparam logic [5:0] F_SYSCALL = 6'd12;
    localparam logic [5:0] F_ADD     = 6'd32;
    localparam logic [5:0] F_ADDU    = 6'd33;
    localparam logic [5:0] F_SUB     = 6'd34;
    localparam logic [5:0] F_SUBU    = 6'd35;
    localparam logic [5:0] F_AND     = 6'd36;
    localparam logic [5:0] F_OR      = 6'd37;
    localparam logic [5:0] F_NOR     = 6'd39;
    localparam logic [5:0] F_SLT     = 6'd42;
    localparam logic [5:0] F_SLTU    = 6'd43;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRA  = 4'd1;
    localparam logic [3:0] ALU_SRL  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;
    localparam logic [3:0] ALU_DEF  = 4'd13;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_A     = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_WB_MEM = 4'd8,
        S_MEM_WR = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_SYS    = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    // Constant shifts take their amount from the shamt field instead of A.
    function automatic logic is_shamt_shift(input logic [5:0] f);
        return (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Memory access bus between the sequencer (master) and memory (slave).
interface mips_multicycle_ctrl_if;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mode;
    logic       mem_ready;

    modport master (output iord, output mem_read, output mem_write, output mode, input mem_ready);
    modport slave  (input iord, input mem_read, input mem_write, input mode, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl_alu_op_dec.sv
// Combinational op/funct decode to ALU operation, immediate extension and
// variable-shift select; shared with the single-cycle decoder.
module mips_alu_op_dec
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       signedext,
    output logic       shift,
    output logic       r_alu
);

    // Map the instruction to its ALU function; r_alu flags a supported R-type ALU funct.
    always_comb begin
        alu_op    = ALU_DEF;
        signedext = 1'b0;
        shift     = 1'b0;
        r_alu     = 1'b0;
        if (op == OP_RTYPE) begin
            r_alu = 1'b1;
            case (funct)
                F_ADD, F_ADDU: alu_op = ALU_ADD;
                F_SUB, F_SUBU: alu_op = ALU_SUB;
                F_AND:         alu_op = ALU_AND;
                F_OR:          alu_op = ALU_OR;
                F_NOR:         alu_op = ALU_NOR;
                F_SLT:         alu_op = ALU_SLT;
                F_SLTU:        alu_op = ALU_SLTU;
                F_SLL:         alu_op = ALU_SLL;
                F_SRL:         alu_op = ALU_SRL;
                F_SRA:         alu_op = ALU_SRA;
                F_SLLV: begin
                    alu_op = ALU_SLL;
                    shift  = 1'b1;
                end
                default:       r_alu  = 1'b0;
            endcase
        end else begin
            case (op)
                OP_ADDI, OP_ADDIU: begin
                    alu_op    = ALU_ADD;
                    signedext = 1'b1;
                end
                OP_SLTI: begin
                    alu_op    = ALU_SLT;
                    signedext = 1'b1;
                end
                OP_SLTIU: alu_op = ALU_SLTU;
                OP_ANDI:  alu_op = ALU_AND;
                OP_ORI:   alu_op = ALU_OR;
                default:  alu_op = ALU_DEF;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: one datapath step per clock, memory ready
// handshake, syscall halt/resume and a retired-instruction counter.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    mips_multicycle_ctrl_if.master mem_bus,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 alu_zero,
    input  logic                 a_gtz,
    input  logic                 v0_is_10,
    input  logic                 resume,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           regdst,
    output logic [1:0]           memtoreg,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 signedext,
    output logic                 shift,
    output logic [3:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic                 syscall_pulse,
    output logic                 illegal,
    output logic                 halted,
    output logic [CNT_W-1:0]     instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             dispatch_s;
    logic [CNT_W-1:0]   instr_count_r;
    logic               retire_s;
    logic [3:0]         dec_alu_op_s;
    logic               dec_signedext_s;
    logic               dec_shift_s;
    logic               dec_r_alu_s;
    logic               iord_s;
    logic               mem_read_s;
    logic               mem_write_s;
    logic [1:0]         mode_s;

    mips_alu_op_dec u_alu_op_dec (
        .op        (op),
        .funct     (funct),
        .alu_op    (dec_alu_op_s),
        .signedext (dec_signedext_s),
        .shift     (dec_shift_s),
        .r_alu     (dec_r_alu_s)
    );

    // Instruction class dispatch out of DECODE; unsupported encodings return to FETCH.
    always_comb begin
        dispatch_s = S_FETCH;
        if (op == OP_RTYPE) begin
            if (dec_r_alu_s)             dispatch_s = S_EXEC_R;
            else if (funct == F_JR)      dispatch_s = S_JUMP;
            else if (funct == F_SYSCALL) dispatch_s = S_SYS;
            else                         dispatch_s = S_FETCH;
        end else begin
            case (op)
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: dispatch_s = S_EXEC_I;
                OP_LW, OP_SW, OP_SH:                                  dispatch_s = S_ADDR;
                OP_BEQ, OP_BNE, OP_BGTZ:                              dispatch_s = S_BRANCH;
                OP_J, OP_JAL:                                         dispatch_s = S_JUMP;
                default:                                              dispatch_s = S_FETCH;
            endcase
        end
    end

    // An instruction retires on the transition out of its final state.
    always_comb begin
        case (state_r)
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_SYS: retire_s = 1'b1;
            S_MEM_WR: retire_s = mem_bus.mem_ready;
            default:  retire_s = 1'b0;
        endcase
    end

    // Sequencer state transitions and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_FETCH;
            instr_count_r <= {CNT_W{1'b0}};
        end else begin
            if (retire_s) instr_count_r <= instr_count_r + CNT_ONE;
            else          instr_count_r <= instr_count_r;
            case (state_r)
                S_FETCH:  state_r <= mem_bus.mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: state_r <= dispatch_s;
                S_EXEC_R: state_r <= S_WB_R;
                S_EXEC_I: state_r <= S_WB_I;
                S_ADDR:   state_r <= (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: state_r <= mem_bus.mem_ready ? S_WB_MEM : S_MEM_RD;
                S_MEM_WR: state_r <= mem_bus.mem_ready ? S_FETCH : S_MEM_WR;
                S_SYS:    state_r <= v0_is_10 ? S_HALT : S_FETCH;
                S_HALT:   state_r <= resume ? S_FETCH : S_HALT;
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    // State-decoded datapath controls; every enable is low outside its own state.
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        regdst        = REGDST_RT;
        memtoreg      = M2R_ALU;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_B;
        signedext     = 1'b0;
        shift         = 1'b0;
        alu_op        = ALU_DEF;
        pc_source     = PCSRC_ALU;
        syscall_pulse = 1'b0;
        illegal       = 1'b0;
        halted        = 1'b0;
        iord_s        = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        mode_s        = MODE_NONE;
        case (state_r)
            S_FETCH: begin
                mem_read_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALU_ADD;
                ir_write   = mem_bus.mem_ready;
                pc_write   = mem_bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADD;
                signedext = 1'b1;
                illegal   = (dispatch_s == S_FETCH);
            end
            S_EXEC_R: begin
                alu_src_a = is_shamt_shift(funct) ? SRCA_SHAMT : SRCA_A;
                alu_op    = dec_alu_op_s;
                shift     = dec_shift_s;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                regdst    = REGDST_RD;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                signedext = dec_signedext_s;
                alu_op    = dec_alu_op_s;
            end
            S_WB_I: reg_write = 1'b1;
            S_ADDR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                signedext = 1'b1;
                alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                memtoreg  = M2R_MDR;
            end
            S_MEM_WR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
                mode_s      = (op == OP_SH) ? MODE_HALF : MODE_WORD;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_A;
                alu_op    = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = ((op == OP_BEQ) & alu_zero) | ((op == OP_BNE) & ~alu_zero) |
                            ((op == OP_BGTZ) & a_gtz);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = (op == OP_RTYPE) ? PCSRC_REG : PCSRC_JUMP;
                if (op == OP_JAL) begin
                    reg_write = 1'b1;
                    regdst    = REGDST_RA;
                    memtoreg  = M2R_PC;
                end else begin
                    reg_write = 1'b0;
                end
            end
            S_SYS:   syscall_pulse = ~v0_is_10;
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign mem_bus.iord      = iord_s;
    assign mem_bus.mem_read  = mem_read_s;
    assign mem_bus.mem_write = mem_write_s;
    assign mem_bus.mode      = mode_s;
    assign instr_count       = instr_count_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle MIPS sequencer: per-instruction vector
// table plus hand sequences for memory stalls, halt/resume and async reset.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] op, funct;
    logic alu_zero, a_gtz, v0_is_10, resume;
    logic pc_write, ir_write, reg_write, signedext, shift, syscall_pulse, illegal, halted;
    logic [1:0] regdst, memtoreg, alu_src_a, alu_src_b, pc_source;
    logic [3:0] alu_op;
    logic [31:0] instr_count;

    logic pc_write2, ir_write2, reg_write2, signedext2, shift2, syscall_pulse2, illegal2, halted2;
    logic [1:0] regdst2, memtoreg2, alu_src_a2, alu_src_b2, pc_source2;
    logic [3:0] alu_op2;
    logic [1:0] instr_count2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    mips_multicycle_ctrl_if bus ();
    mips_multicycle_ctrl_if bus2 ();
    assign bus2.mem_ready = bus.mem_ready;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mem_bus(bus), .op(op), .funct(funct),
        .alu_zero(alu_zero), .a_gtz(a_gtz), .v0_is_10(v0_is_10), .resume(resume),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .regdst(regdst),
        .memtoreg(memtoreg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .signedext(signedext), .shift(shift), .alu_op(alu_op), .pc_source(pc_source),
        .syscall_pulse(syscall_pulse), .illegal(illegal), .halted(halted),
        .instr_count(instr_count)
    );

    mips_multicycle_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .mem_bus(bus2), .op(op), .funct(funct),
        .alu_zero(alu_zero), .a_gtz(a_gtz), .v0_is_10(v0_is_10), .resume(resume),
        .pc_write(pc_write2), .ir_write(ir_write2), .reg_write(reg_write2), .regdst(regdst2),
        .memtoreg(memtoreg2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
        .signedext(signedext2), .shift(shift2), .alu_op(alu_op2), .pc_source(pc_source2),
        .syscall_pulse(syscall_pulse2), .illegal(illegal2), .halted(halted2),
        .instr_count(instr_count2)
    );

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       gtz;
        int         cycles;
        logic       pcw;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] aop;
        logic       sx;
        logic       sh;
        int         retire;
        int         ill_n;
        int         sys_n;
        int         mw_n;
        logic [1:0] mw_mode;
    } vec_t;

    vec_t vecs [27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic in_fetch();
        return bus.mem_read && !bus.iord;
    endfunction

    // Runs one instruction from a FETCH cycle with mem_ready held high.
    task automatic run_instr(input vec_t v, output int cycles, output logic [17:0] snap,
                             output int ill_n, output int sys_n, output int mw_n,
                             output logic [1:0] mw_mode);
        bit done = 1'b0;
        op = v.op; funct = v.funct; alu_zero = v.zero; a_gtz = v.gtz;
        v0_is_10 = 1'b0; bus.mem_ready = 1'b1;
        cycles = 99; snap = '0; ill_n = 0; sys_n = 0; mw_n = 0; mw_mode = 2'b00;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (c == 2)
                snap = {pc_write, pc_source, reg_write, regdst, memtoreg, alu_src_a,
                        alu_src_b, alu_op, signedext, shift};
            if (c > 0 && in_fetch()) begin
                cycles = c;
                done = 1'b1;
            end else begin
                if (illegal) ill_n++;
                if (syscall_pulse) sys_n++;
                if (bus.mem_write) begin
                    mw_n++;
                    mw_mode = bus.mode;
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int cycles, ill_n, sys_n, mw_n, cnt_rd, wb_seen, bad;
        logic [17:0] snap;
        logic [1:0] mw_mode;
        bit done;

        //                name     op     funct  z     g     cyc pcw   pcs    rw    rd     m2r    sa     sb     aop    sx    sh   ret ill sys mw mode
        vecs[0]  = '{"ADD",    6'd0,  6'd32, 1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd5,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[1]  = '{"SUB",    6'd0,  6'd34, 1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd6,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[2]  = '{"SLL",    6'd0,  6'd0,  1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 4'd0,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[3]  = '{"SRA",    6'd0,  6'd3,  1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 4'd1,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[4]  = '{"SLLV",   6'd0,  6'd4,  1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd0,  1'b0, 1'b1, 1, 0, 0, 0, 2'b00};
        vecs[5]  = '{"NOR",    6'd0,  6'd39, 1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd10, 1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[6]  = '{"SLTU",   6'd0,  6'd43, 1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd12, 1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[7]  = '{"ADDI",   6'd8,  6'd0,  1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 4'd5,  1'b1, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[8]  = '{"SLTI",   6'd10, 6'd0,  1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 4'd11, 1'b1, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[9]  = '{"SLTIU",  6'd11, 6'd0,  1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 4'd12, 1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[10] = '{"ORI",    6'd13, 6'd0,  1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 4'd8,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[11] = '{"BEQ_T",  6'd4,  6'd0,  1'b1, 1'b0, 3, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd6,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[12] = '{"BEQ_N",  6'd4,  6'd0,  1'b0, 1'b0, 3, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd6,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[13] = '{"BNE_T",  6'd5,  6'd0,  1'b0, 1'b0, 3, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd6,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[14] = '{"BNE_N",  6'd5,  6'd0,  1'b1, 1'b0, 3, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd6,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[15] = '{"BGTZ_T", 6'd7,  6'd0,  1'b0, 1'b1, 3, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd6,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[16] = '{"BGTZ_N", 6'd7,  6'd0,  1'b1, 1'b0, 3, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd6,  1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[17] = '{"J",      6'd2,  6'd0,  1'b0, 1'b0, 3, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'd13, 1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[18] = '{"JAL",    6'd3,  6'd0,  1'b0, 1'b0, 3, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 4'd13, 1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[19] = '{"JR",     6'd0,  6'd8,  1'b0, 1'b0, 3, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'd13, 1'b0, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[20] = '{"SW",     6'd43, 6'd0,  1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 4'd5,  1'b1, 1'b0, 1, 0, 0, 1, 2'b10};
        vecs[21] = '{"SH",     6'd41, 6'd0,  1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 4'd5,  1'b1, 1'b0, 1, 0, 0, 1, 2'b01};
        vecs[22] = '{"LW",     6'd35, 6'd0,  1'b0, 1'b0, 5, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 4'd5,  1'b1, 1'b0, 1, 0, 0, 0, 2'b00};
        vecs[23] = '{"SYSCALL",6'd0,  6'd12, 1'b0, 1'b0, 3, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'd13, 1'b0, 1'b0, 1, 0, 1, 0, 2'b00};
        vecs[24] = '{"ILL_OP", 6'd63, 6'd0,  1'b0, 1'b0, 2, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 4'd5,  1'b0, 1'b0, 0, 1, 0, 0, 2'b00};
        vecs[25] = '{"ILL_OP6",6'd6,  6'd0,  1'b0, 1'b0, 2, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 4'd5,  1'b0, 1'b0, 0, 1, 0, 0, 2'b00};
        vecs[26] = '{"ILL_FN", 6'd0,  6'd38, 1'b0, 1'b0, 2, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 4'd5,  1'b0, 1'b0, 0, 1, 0, 0, 2'b00};

        rst_n = 1'b0; op = 6'd0; funct = 6'd0; alu_zero = 1'b0; a_gtz = 1'b0;
        v0_is_10 = 1'b0; resume = 1'b0; bus.mem_ready = 1'b0;
        #1;
        chk("reset_count", instr_count, 32'd0);
        chk("reset_fetch_read", {31'd0, in_fetch()}, 32'd1);
        chk("reset_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b1;

        // FETCH holds while memory is not ready.
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (!(in_fetch() && !ir_write && !pc_write)) bad++;
            @(posedge clk); @(negedge clk);
        end
        chk("fetch_stall", bad, 32'd0);

        foreach (vecs[i]) begin
            run_instr(vecs[i], cycles, snap, ill_n, sys_n, mw_n, mw_mode);
            exp_cnt += vecs[i].retire;
            chk({vecs[i].name, "_cycles"}, cycles, vecs[i].cycles);
            chk({vecs[i].name, "_ctrl"}, {14'd0, snap},
                {14'd0, vecs[i].pcw, vecs[i].pcs, vecs[i].rw, vecs[i].rd, vecs[i].m2r,
                 vecs[i].sa, vecs[i].sb, vecs[i].aop, vecs[i].sx, vecs[i].sh});
            chk({vecs[i].name, "_illegal"}, ill_n, vecs[i].ill_n);
            chk({vecs[i].name, "_syscall"}, sys_n, vecs[i].sys_n);
            chk({vecs[i].name, "_mem_write"}, {28'd0, mw_n[1:0], mw_mode},
                {28'd0, vecs[i].mw_n[1:0], vecs[i].mw_mode});
            chk({vecs[i].name, "_count"}, instr_count, exp_cnt);
        end

        // LW with memory not ready for two extra cycles in MEM_RD.
        op = 6'd35; funct = 6'd0; cnt_rd = 0; wb_seen = 0; cycles = 99; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            bus.mem_ready = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            #1;
            if (c > 0 && in_fetch()) begin
                cycles = c;
                done = 1'b1;
            end else begin
                if (bus.mem_read && bus.iord) cnt_rd++;
                if (reg_write && memtoreg == 2'b01 && regdst == 2'b00) wb_seen++;
                @(posedge clk); @(negedge clk);
            end
        end
        exp_cnt++;
        chk("lw_stall_cycles", cycles, 32'd7);
        chk("lw_stall_read_cycles", cnt_rd, 32'd3);
        chk("lw_stall_wb_mdr", wb_seen, 32'd1);
        chk("lw_stall_count", instr_count, exp_cnt);

        // SYSCALL with $v0 == 10 halts until resume.
        op = 6'd0; funct = 6'd12; v0_is_10 = 1'b1; bus.mem_ready = 1'b1; bad = 0; sys_n = 0;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (syscall_pulse) sys_n++;
            if (c >= 3 && !(halted && !pc_write && !ir_write && !bus.mem_read &&
                            !bus.mem_write && !reg_write)) bad++;
            @(posedge clk); @(negedge clk);
        end
        exp_cnt++;
        chk("halt_quiet", bad, 32'd0);
        chk("halt_no_pulse", sys_n, 32'd0);
        chk("halt_count", instr_count, exp_cnt);
        v0_is_10 = 1'b0;
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_fetch", {31'd0, in_fetch()}, 32'd1);
        chk("wrap_count", {30'd0, instr_count2}, exp_cnt % 4);
        @(negedge clk);

        // SH stalled in MEM_WR, then async reset in the middle of the write.
        op = 6'd41; funct = 6'd0;
        for (int c = 0; c < 5; c++) begin
            bus.mem_ready = (c >= 3) ? 1'b0 : 1'b1;
            #1;
            if (c == 3)
                chk("sh_mem_wr", {29'd0, bus.mem_write, bus.iord, bus.mode[0]}, 32'd7);
            if (c == 3)
                chk("sh_mode", {30'd0, bus.mode}, 32'd1);
            if (c < 4) begin
                @(posedge clk); @(negedge clk);
            end
        end
        chk("sh_wait_write", {31'd0, bus.mem_write}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("rst_mid_write", {31'd0, bus.mem_write}, 32'd0);
        chk("rst_mid_fetch", {31'd0, in_fetch()}, 32'd1);
        chk("rst_mid_count", instr_count, exp_cnt);
        chk("rst_mid_count_small", {30'd0, instr_count2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with an FSM that drives PC, IR, memory, ALU and register-file enables one step per clock. It uses the same opcode/funct set and ALU_OP encoding as the single-cycle decoder. It handles a memory ready handshake, syscall halt/resume, and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag (A==B on SUB)
a_gtz  in  1  register A > 0 signed, from datapath
v0_is_10  in  1  $v0 == 10, sampled in SYS state
mem_ready  in  1  memory completes current access this cycle
resume  in  1  one-cycle pulse leaves HALT
pc_write  out  1  load PC
ir_write  out  1  load IR and MDR
iord  out  1  0: address=PC, 1: address=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mode  out  2  01 halfword (SH), 10 word
reg_write  out  1  register file write
regdst  out  2  00 rt, 01 rd, 10 $31
memtoreg  out  2  00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  2  00 PC, 01 A, 10 shamt
alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
signedext  out  1  1 sign-extend imm, 0 zero-extend
shift  out  1  SLLV variable-shift select
alu_op  out  4  5 add, 0 sll, 1 sra, 2 srl, 6 sub, 7 and, 8 or, 10 nor, 11 slt, 12 sltu, 13 default
pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 A (JR)
syscall_pulse  out  1  one cycle on non-halting syscall
illegal  out  1  one cycle on unsupported op/funct
halted  out  1  high while in HALT
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_n=0): state=FETCH, instr_count=0. All outputs are Moore/state-decoded; all enables are 0 outside their listed states.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=5. Stays in FETCH while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, pc_source=00, next DECODE.
- DECODE: alu_src_a=00, alu_src_b=11, alu_op=5, signedext=1 (precomputes branch target into ALUOut). Dispatch on op/funct:
  - R-ALU → EXEC_R
  - op 8-13 → EXEC_I
  - op 35/43/41 → ADDR
  - op 4/5/7 → BRANCH
  - op 2/3, or R with funct 8 → JUMP
  - funct 12 → SYS
  - other → FETCH with illegal=1 (no retire).
- EXEC_R: alu_src_a=10 for SLL/SRL/SRA, else 01; alu_src_b=00; alu_op per funct; shift=1 for SLLV. Next WB_R.
- WB_R: reg_write=1, regdst=01, memtoreg=00. Retire → FETCH.
- EXEC_I: alu_src_a=01, alu_src_b=10. signedext=1 for ADDI/ADDIU/SLTI, 0 for ANDI/ORI/SLTIU. alu_op 5/5/11/12/7/8. Next WB_I.
- WB_I: reg_write=1, regdst=00, memtoreg=00. Retire.
- ADDR: alu_src_a=01, alu_src_b=10, signedext=1, alu_op=5. Next MEM_RD for LW, MEM_WR for SW/SH.
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then ir_write stays 0; MDR loads; next WB_MEM.
- WB_MEM: reg_write=1, regdst=00, memtoreg=01. Retire.
- MEM_WR: mem_write=1, iord=1, mode=01 (SH) or 10 (SW). Waits for mem_ready, then retires.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=6, pc_source=01. pc_write = (BEQ & alu_zero) | (BNE & ~alu_zero) | (BGTZ & a_gtz). Retire.
- JUMP: pc_write=1, pc_source=10 for J/JAL, 11 for JR. For JAL also reg_write=1, regdst=10, memtoreg=10 (PC already +4). Retire.
- SYS: v0_is_10=1 → HALT, retire. Otherwise syscall_pulse=1, retire, → FETCH.
- HALT: halted=1, no enables. On resume=1 → FETCH. resume in any other state is ignored.
- Retire: instr_count+1 on the transition out of the final state; wraps to 0 at all-ones.
- mem_ready held high across consecutive states is consumed only in FETCH/MEM_RD/MEM_WR.
- Reset mid-access drops mem_read/mem_write in the same cycle (async).

Decomposition:
- Shared package mips_pkg holds: opcode/funct constants, ALU_OP codes, the regdst/memtoreg/pc_source/alu_src encodings, and the state enum.
- One natural sub-module, mips_alu_op_dec: combinational op/funct → alu_op/signedext/shift, reusable by the single-cycle decoder.

Test Plan:
- ADD r3,r1,r2 (op 0, funct 32), mem_ready=1 in FETCH → 4 cycles FETCH/DECODE/EXEC_R/WB_R; alu_op=5 in EXEC_R; reg_write=1, regdst=01 in WB_R; instr_count 0→1.
- LW (op 35) with mem_ready low 2 extra cycles in MEM_RD → mem_read, iord=1 held 3 cycles; 5+2 cycles total; WB_MEM memtoreg=01.
- BEQ (op 4) with alu_zero=1 → BRANCH pc_write=1, pc_source=01. Repeat with alu_zero=0 → pc_write=0. BGTZ with a_gtz=1 → pc_write=1.
- JAL (op 3) → JUMP: pc_write=1, pc_source=10, reg_write=1, regdst=10, memtoreg=10. JR (funct 8) → pc_source=11, reg_write=0.
- SYSCALL with v0_is_10=0 → syscall_pulse 1 cycle, back to FETCH. With v0_is_10=1 → halted=1 for 10 cycles with no enables; resume pulse → FETCH next cycle.
- SH (op 41) → MEM_WR mode=01, mem_write=1. Assert rst_n=0 mid-MEM_WR → mem_write=0 immediately, state FETCH, instr_count=0.
